// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared opcodes, FSM states and requester ids for the RAM access arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } ram_op_e;

    typedef enum logic [1:0] {IDLE, OWN, WAIT_RD} arb_state_e;

    localparam logic REQ_SPI  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin pick; a tie goes to the requester not granted last.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       winner
);
    assign winner = (&valid) ? ~last_grant : valid[REQ_HOST];
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: locks the RAM command port to the SPI slave or the host for a whole
// address+data transaction and routes the read response back to the owner.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_TIMEOUT   = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cmd_valid,
    input  logic [9:0] spi_cmd,
    output logic       spi_cmd_ready,
    output logic       spi_rsp_valid,
    output logic [7:0] spi_rsp_data,
    output logic       spi_rsp_err,
    input  logic       host_cmd_valid,
    input  logic [9:0] host_cmd,
    output logic       host_cmd_ready,
    output logic       host_rsp_valid,
    output logic [7:0] host_rsp_data,
    output logic       host_rsp_err,
    output logic       ram_rx_valid,
    output logic [9:0] ram_din,
    input  logic       ram_tx_valid,
    input  logic [7:0] ram_dout
);
    localparam int CW = $clog2(max2(RD_TIMEOUT, LOCK_TIMEOUT));

    arb_state_e    state, state_nx;
    logic          owner, owner_nx, last_grant, last_grant_nx, winner;
    logic [CW-1:0] cnt, cnt_nx;
    logic          hs, rd_done, rd_expire, rsp;
    logic [9:0]    cmd;
    ram_op_e       op;

    rr_pick2 u_pick (
        .valid      ({host_cmd_valid, spi_cmd_valid}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign spi_cmd_ready  = state == OWN && owner == REQ_SPI;
    assign host_cmd_ready = state == OWN && owner == REQ_HOST;
    assign cmd            = owner ? host_cmd : spi_cmd;
    assign op             = ram_op_e'(cmd[9:8]);
    assign hs             = (spi_cmd_ready && spi_cmd_valid) || (host_cmd_ready && host_cmd_valid);
    // Returned data beats a simultaneous timeout expiry.
    assign rd_done        = state == WAIT_RD && ram_tx_valid;
    assign rd_expire      = state == WAIT_RD && !ram_tx_valid && cnt == CW'(RD_TIMEOUT - 1);
    assign rsp            = rd_done || rd_expire;

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        case (state)
            IDLE: begin
                if (spi_cmd_valid || host_cmd_valid) begin
                    state_nx = OWN;
                    owner_nx = winner;
                    cnt_nx   = '0;
                end
            end
            OWN: begin
                if (hs) begin
                    cnt_nx = '0;
                    if (op == OP_WR_DATA) begin
                        state_nx      = IDLE;
                        last_grant_nx = owner;
                    end else if (op == OP_RD_DATA) begin
                        state_nx = WAIT_RD;
                    end
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nx      = IDLE;
                    last_grant_nx = owner;
                    cnt_nx        = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_RD: begin
                if (rsp) begin
                    state_nx      = IDLE;
                    last_grant_nx = owner;
                    cnt_nx        = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= REQ_SPI;
            last_grant     <= REQ_HOST;
            cnt            <= '0;
            ram_rx_valid   <= 1'b0;
            ram_din        <= '0;
            spi_rsp_valid  <= 1'b0;
            spi_rsp_data   <= '0;
            spi_rsp_err    <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rsp_data  <= '0;
            host_rsp_err   <= 1'b0;
        end else begin
            state          <= state_nx;
            owner          <= owner_nx;
            last_grant     <= last_grant_nx;
            cnt            <= cnt_nx;
            ram_rx_valid   <= hs;
            ram_din        <= hs ? cmd : ram_din;
            spi_rsp_valid  <= rsp && owner == REQ_SPI;
            spi_rsp_data   <= (rd_done && owner == REQ_SPI) ? ram_dout : '0;
            spi_rsp_err    <= rd_expire && owner == REQ_SPI;
            host_rsp_valid <= rsp && owner == REQ_HOST;
            host_rsp_data  <= (rd_done && owner == REQ_HOST) ? ram_dout : '0;
            host_rsp_err   <= rd_expire && owner == REQ_HOST;
        end
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Shares the single command port of the dual-port RAM between two requesters: the SPI slave (requester 0) and a local host port (requester 1). Both requesters issue 10-bit RAM commands with the RAM's encoding: bits[9:8] 00 = write address, 01 = write data, 10 = read address, 11 = read data.
The arbiter locks the RAM to one requester for a whole transaction (address command plus data command). It then routes the 8-bit read response back to that owner. It sits between slave/host and Dual_port_RAM, driving the RAM's rx_valid/din inputs and consuming its tx_valid/dout outputs.

Parameters:
RD_TIMEOUT, 16, max cycles in WAIT_RD waiting for ram_tx_valid before an error response is returned (≥2).
LOCK_TIMEOUT, 64, max idle cycles an owner may hold the lock in OWN without issuing a command.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
spi_cmd_valid  in  1  SPI requester has a command
spi_cmd  in  10  SPI command {op[1:0], payload[7:0]}
spi_cmd_ready  out  1  command accepted this cycle when valid&ready
spi_rsp_valid  out  1  one-cycle pulse: read response for SPI
spi_rsp_data  out  8  read data (0 when error)
spi_rsp_err  out  1  qualifies spi_rsp_valid: read timed out
host_cmd_valid, host_cmd, host_cmd_ready, host_rsp_valid, host_rsp_data, host_rsp_err: same widths/meanings, for the host requester
ram_rx_valid  out  1  command strobe to RAM
ram_din  out  10  command to RAM
ram_tx_valid  in  1  RAM read data valid
ram_dout  in  8  RAM read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=host (so SPI wins the first tie), counter=0. All outputs 0. An in-flight read is abandoned and no response is produced.
- States:
  - IDLE → OWN: taken when any cmd_valid is high. Owner = the only valid requester; if both are valid, owner = the requester ≠ last_grant (round-robin). No ready is asserted in IDLE.
  - OWN: owner's cmd_ready=1 (combinational from state and owner); the other requester's ready=0. On handshake:
    - ram_din <= cmd and ram_rx_valid <= 1 for exactly one cycle (registered, 1-cycle latency).
    - counter is cleared.
    - op 00/10: stay in OWN.
    - op 01: → IDLE, last_grant <= owner.
    - op 11: → WAIT_RD, counter <= 0.
    - No handshake: counter++. At counter==LOCK_TIMEOUT-1 → IDLE, last_grant <= owner (lock released, nothing sent to RAM).
  - WAIT_RD: both readies 0.
    - ram_tx_valid=1: owner rsp_valid <= 1, rsp_data <= ram_dout, rsp_err <= 0; → IDLE, last_grant <= owner.
    - Otherwise counter++. At counter==RD_TIMEOUT-1: rsp_valid <= 1, rsp_err <= 1, rsp_data <= 0; → IDLE.
- rsp outputs are registered and pulse exactly one cycle; the non-owner's rsp_valid is always 0.
- ram_tx_valid outside WAIT_RD is ignored and dropped. ram_tx_valid on the same cycle as the timeout expiry: the data wins (err=0).
- Op 01 or 11 as the first command of a lock is legal and forwarded; 01 releases the lock immediately.
- Minimum per-transaction cost: 1 IDLE cycle; write = IDLE + 2 handshakes; back-to-back transactions from the same requester are allowed but alternate under contention.
- The counter is sized $clog2(max(RD_TIMEOUT, LOCK_TIMEOUT)) bits; no wrap is possible because state exits at the limit.

Decomposition:
- Package ram_arb_pkg: typedef enum {OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11} ram_op_e; typedef enum {IDLE, OWN, WAIT_RD} arb_state_e; localparam REQ_SPI=0, REQ_HOST=1.
- One sub-module: rr_pick2 (two-request round-robin selector, inputs valid[1:0] and last_grant, output winner), combinational.
- Everything else is in one always_ff plus output muxing.

Test Plan:
1. SPI only: 00_0x05, then 01_0xA3 → ram_din 0x005 then 0x1A3, each with a 1-cycle ram_rx_valid; lock released; host_cmd_ready never high.
2. Host read: 10_0x05, then 11_0x00; RAM returns 0xA3 two cycles later → host_rsp_valid pulse with data 0xA3, err 0; spi_rsp_valid stays 0.
3. Both valid from reset → SPI granted first; after its write completes, host is granted while SPI remains valid (alternation over 4 transactions: S,H,S,H).
4. Owner issues 11 and RAM never asserts tx_valid → rsp_valid with err=1, data 0x00 exactly RD_TIMEOUT cycles after entering WAIT_RD; next requester is granted.
5. SPI sends 00 and then idles → lock released after LOCK_TIMEOUT cycles; waiting host is granted; stray ram_tx_valid in OWN produces no response.
6. Assert rst_n=0 during WAIT_RD → all outputs 0 immediately; after release, no rsp pulse and state is IDLE.
